trd_sched: RTL and testbench

Per-thread PC register file and round-robin thread scheduler for the 8-thread barrel pipeline. Each cycle it commits the next-PC values and write strobes produced by the PC selector, tracks which threads are stalled on outstanding I/D-cache misses, and picks one ready thread to issue. It drives the `cur_trd` / `cur_pc` pair consumed by fetch and fed back into the PC selector.

---
 rtl/trd_sched_pkg.sv | 10 +
 rtl/trd_sched_rr_arb8.sv | 27 ++
 rtl/trd_sched.sv | 114 +++++++++++
 tb/tb_trd_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/trd_sched_pkg.sv
// Shared constants and types for the barrel-pipeline thread scheduler.
package trd_sched_pkg;

    localparam int unsigned NUM_TRD  = 8;
    localparam logic [31:0] START_PC = 32'h0000_1000;
    localparam logic [31:0] HANDLER  = 32'h0000_0100;

    typedef logic [2:0] trd_id_t;

endpackage

// File: rtl/trd_sched_rr_arb8.sv
// Combinational 8-way round-robin picker: searches last+1 .. last+8 (mod 8)
// for the first asserted request.
module rr_arb8
    import trd_sched_pkg::*;
(
    input  logic [7:0] req,
    input  logic [2:0] last,
    output logic       gnt_vld,
    output logic [2:0] gnt_id
);

    always_comb begin
        trd_id_t idx;
        idx     = '0;
        gnt_vld = 1'b0;
        gnt_id  = last;
        for (int unsigned k = 1; k <= 8; k++) begin
            // k = 8 truncates to 0, so the last candidate is 'last' itself
            idx = trd_id_t'(last + trd_id_t'(k));
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx;
            end
        end
    end

endmodule

// File: rtl/trd_sched.sv
// Per-thread PC file, cache-miss stall tracking and round-robin issue
// selection for the 8-thread barrel pipeline.
module trd_sched
    import trd_sched_pkg::*;
#(
    parameter int unsigned NUM_TRD  = trd_sched_pkg::NUM_TRD,
    parameter logic [31:0] START_PC = trd_sched_pkg::START_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] nxt_pc_0,
    input  logic [31:0] nxt_pc_1,
    input  logic [31:0] nxt_pc_2,
    input  logic [31:0] nxt_pc_3,
    input  logic [31:0] nxt_pc_4,
    input  logic [31:0] nxt_pc_5,
    input  logic [31:0] nxt_pc_6,
    input  logic [31:0] nxt_pc_7,
    input  logic [7:0]  pc_wr,
    input  logic [7:0]  trd_en,
    input  logic        i_miss,
    input  logic [2:0]  i_miss_trd,
    input  logic        d_miss,
    input  logic [2:0]  d_miss_trd,
    input  logic        fill_done,
    input  logic [2:0]  fill_trd,
    output logic        cur_vld,
    output logic [2:0]  cur_trd,
    output logic [31:0] cur_pc,
    output logic [7:0]  stall_mask
);

    logic [31:0] nxt_pc [NUM_TRD];
    logic [31:0] pc     [NUM_TRD];
    logic [7:0]  stall;
    logic [7:0]  miss_set;
    logic [7:0]  fill_clr;
    logic [7:0]  ready;
    trd_id_t     last;
    logic        gnt_vld;
    trd_id_t     gnt_id;
    logic [31:0] pick_pc;

    always_comb begin
        nxt_pc[0] = nxt_pc_0;
        nxt_pc[1] = nxt_pc_1;
        nxt_pc[2] = nxt_pc_2;
        nxt_pc[3] = nxt_pc_3;
        nxt_pc[4] = nxt_pc_4;
        nxt_pc[5] = nxt_pc_5;
        nxt_pc[6] = nxt_pc_6;
        nxt_pc[7] = nxt_pc_7;
    end

    always_comb begin
        miss_set = '0;
        fill_clr = '0;
        if (i_miss)    miss_set[i_miss_trd] = 1'b1;
        if (d_miss)    miss_set[d_miss_trd] = 1'b1;
        if (fill_done) fill_clr[fill_trd]   = 1'b1;
    end

    // A same-cycle fill is deliberately not allowed to unmask the thread.
    assign ready = trd_en & ~stall & ~miss_set;

    rr_arb8 u_arb (
        .req     (ready),
        .last    (last),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    // Bypass so the PC committed at this edge is the one issued.
    assign pick_pc = pc_wr[gnt_id] ? nxt_pc[gnt_id] : pc[gnt_id];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_TRD; i++) begin
                pc[i] <= START_PC;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_TRD; i++) begin
                if (pc_wr[i]) pc[i] <= nxt_pc[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall <= '0;
        end else begin
            stall <= (stall & ~fill_clr) | miss_set;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_vld <= 1'b0;
            cur_trd <= '0;
            cur_pc  <= START_PC;
            last    <= trd_id_t'(7);
        end else if (gnt_vld) begin
            cur_vld <= 1'b1;
            cur_trd <= gnt_id;
            cur_pc  <= pick_pc;
            last    <= gnt_id;
        end else begin
            cur_vld <= 1'b0;
        end
    end

    assign stall_mask = stall;

endmodule

// File: tb/tb_trd_sched.sv
// Directed self-checking bench for trd_sched.
module tb_trd_sched;
    import trd_sched_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] nxt_pc_0, nxt_pc_1, nxt_pc_2, nxt_pc_3;
    logic [31:0] nxt_pc_4, nxt_pc_5, nxt_pc_6, nxt_pc_7;
    logic [7:0]  pc_wr;
    logic [7:0]  trd_en;
    logic        i_miss;
    logic [2:0]  i_miss_trd;
    logic        d_miss;
    logic [2:0]  d_miss_trd;
    logic        fill_done;
    logic [2:0]  fill_trd;
    logic        cur_vld;
    logic [2:0]  cur_trd;
    logic [31:0] cur_pc;
    logic [7:0]  stall_mask;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    trd_sched #(.NUM_TRD(8), .START_PC(START_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .nxt_pc_0   (nxt_pc_0),
        .nxt_pc_1   (nxt_pc_1),
        .nxt_pc_2   (nxt_pc_2),
        .nxt_pc_3   (nxt_pc_3),
        .nxt_pc_4   (nxt_pc_4),
        .nxt_pc_5   (nxt_pc_5),
        .nxt_pc_6   (nxt_pc_6),
        .nxt_pc_7   (nxt_pc_7),
        .pc_wr      (pc_wr),
        .trd_en     (trd_en),
        .i_miss     (i_miss),
        .i_miss_trd (i_miss_trd),
        .d_miss     (d_miss),
        .d_miss_trd (d_miss_trd),
        .fill_done  (fill_done),
        .fill_trd   (fill_trd),
        .cur_vld    (cur_vld),
        .cur_trd    (cur_trd),
        .cur_pc     (cur_pc),
        .stall_mask (stall_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {nxt_pc_0, nxt_pc_1, nxt_pc_2, nxt_pc_3} = '0;
        {nxt_pc_4, nxt_pc_5, nxt_pc_6, nxt_pc_7} = '0;
        pc_wr = '0; trd_en = '0;
        i_miss = 0; i_miss_trd = '0; d_miss = 0; d_miss_trd = '0;
        fill_done = 0; fill_trd = '0;
        #3;
        chk_cnt++; if (cur_vld !== 1'b0) $display("FAIL reset_vld: got %b expected 0", cur_vld); else pass_cnt++;
        chk_cnt++; if (cur_trd !== 3'd0) $display("FAIL reset_trd: got %0d expected 0", cur_trd); else pass_cnt++;
        chk_cnt++; if (cur_pc !== START_PC) $display("FAIL reset_pc: got %h expected %h", cur_pc, START_PC); else pass_cnt++;
        chk_cnt++; if (stall_mask !== 8'h00) $display("FAIL reset_stall: got %h expected 00", stall_mask); else pass_cnt++;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_cnt++; if (cur_vld !== 1'b0) $display("FAIL idle_no_en_vld: got %b expected 0", cur_vld); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_trd;
        trd_en = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            exp_trd = 3'(i % 8);
            chk_cnt++; if (cur_vld !== 1'b1) $display("FAIL rr_vld[%0d]: got %b expected 1", i, cur_vld); else pass_cnt++;
            chk_cnt++; if (cur_trd !== exp_trd) $display("FAIL rr_trd[%0d]: got %0d expected %0d", i, cur_trd, exp_trd); else pass_cnt++;
            chk_cnt++; if (cur_pc !== START_PC) $display("FAIL rr_pc[%0d]: got %h expected %h", i, cur_pc, START_PC); else pass_cnt++;
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_pc;
        trd_en = 8'h01;
        for (int k = 0; k < 6; k++) begin
            exp_pc   = START_PC + 32'(k);
            pc_wr    = 8'h01;
            nxt_pc_0 = exp_pc;
            tick();
            chk_cnt++; if (cur_trd !== 3'd0 || cur_vld !== 1'b1) $display("FAIL byp_trd[%0d]: got vld=%b trd=%0d expected vld=1 trd=0", k, cur_vld, cur_trd); else pass_cnt++;
            chk_cnt++; if (cur_pc !== exp_pc) $display("FAIL byp_pc[%0d]: got %h expected %h", k, cur_pc, exp_pc); else pass_cnt++;
        end
        pc_wr    = '0;
        nxt_pc_0 = 32'hDEAD_BEEF;
        tick();
        chk_cnt++; if (cur_pc !== START_PC + 32'd5) $display("FAIL byp_hold_pc: got %h expected %h", cur_pc, START_PC + 32'd5); else pass_cnt++;
    endtask

    task automatic test_miss_skip();
        logic [2:0]  seq [6];
        logic [31:0] exp_pc;
        seq = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
        trd_en = 8'hFF;
        tick();
        tick();
        chk_cnt++; if (cur_trd !== 3'd2) $display("FAIL miss_pre_trd: got %0d expected 2", cur_trd); else pass_cnt++;
        d_miss = 1'b1; d_miss_trd = 3'd3;
        tick();
        d_miss = 1'b0;
        chk_cnt++; if (cur_trd !== 3'd4) $display("FAIL miss_skip_trd: got %0d expected 4", cur_trd); else pass_cnt++;
        chk_cnt++; if (stall_mask !== 8'h08) $display("FAIL miss_stall: got %h expected 08", stall_mask); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_pc = (seq[i] == 3'd0) ? START_PC + 32'd5 : START_PC;
            chk_cnt++; if (cur_trd !== seq[i]) $display("FAIL miss_seq_trd[%0d]: got %0d expected %0d", i, cur_trd, seq[i]); else pass_cnt++;
            chk_cnt++; if (cur_pc !== exp_pc) $display("FAIL miss_seq_pc[%0d]: got %h expected %h", i, cur_pc, exp_pc); else pass_cnt++;
        end
        fill_done = 1'b1; fill_trd = 3'd3; trd_en = 8'h08;
        tick();
        fill_done = 1'b0;
        chk_cnt++; if (cur_vld !== 1'b0) $display("FAIL fill_n1_vld: got %b expected 0", cur_vld); else pass_cnt++;
        chk_cnt++; if (cur_trd !== 3'd2) $display("FAIL fill_n1_hold: got %0d expected 2", cur_trd); else pass_cnt++;
        chk_cnt++; if (stall_mask !== 8'h00) $display("FAIL fill_stall: got %h expected 00", stall_mask); else pass_cnt++;
        tick();
        chk_cnt++; if (cur_vld !== 1'b1 || cur_trd !== 3'd3) $display("FAIL fill_n2: got vld=%b trd=%0d expected vld=1 trd=3", cur_vld, cur_trd); else pass_cnt++;
    endtask

    task automatic test_set_wins();
        trd_en = 8'hFF;
        i_miss = 1'b1; i_miss_trd = 3'd5;
        tick();
        chk_cnt++; if (cur_trd !== 3'd4) $display("FAIL sw_first_trd: got %0d expected 4", cur_trd); else pass_cnt++;
        chk_cnt++; if (stall_mask !== 8'h20) $display("FAIL sw_stall_a: got %h expected 20", stall_mask); else pass_cnt++;
        fill_done = 1'b1; fill_trd = 3'd5;
        tick();
        i_miss = 1'b0; fill_done = 1'b0;
        chk_cnt++; if (cur_trd !== 3'd6) $display("FAIL sw_skip_trd: got %0d expected 6", cur_trd); else pass_cnt++;
        chk_cnt++; if (stall_mask !== 8'h20) $display("FAIL sw_stall_b: got %h expected 20", stall_mask); else pass_cnt++;
        tick();
        chk_cnt++; if (cur_trd !== 3'd7) $display("FAIL sw_next_trd: got %0d expected 7", cur_trd); else pass_cnt++;
        i_miss = 1'b1; i_miss_trd = 3'd1;
        d_miss = 1'b1; d_miss_trd = 3'd2;
        tick();
        i_miss = 1'b0; d_miss = 1'b0;
        chk_cnt++; if (cur_trd !== 3'd0) $display("FAIL dual_wrap_trd: got %0d expected 0", cur_trd); else pass_cnt++;
        chk_cnt++; if (stall_mask !== 8'h26) $display("FAIL dual_stall: got %h expected 26", stall_mask); else pass_cnt++;
        tick();
        chk_cnt++; if (cur_trd !== 3'd3) $display("FAIL dual_skip_trd: got %0d expected 3", cur_trd); else pass_cnt++;
    endtask

    task automatic test_disable();
        trd_en = 8'h00;
        tick();
        chk_cnt++; if (cur_vld !== 1'b0) $display("FAIL dis_vld: got %b expected 0", cur_vld); else pass_cnt++;
        tick();
        chk_cnt++; if (cur_trd !== 3'd3 || cur_pc !== START_PC) $display("FAIL dis_hold: got trd=%0d pc=%h expected trd=3 pc=%h", cur_trd, cur_pc, START_PC); else pass_cnt++;
        chk_cnt++; if (stall_mask !== 8'h26) $display("FAIL dis_stall_keep: got %h expected 26", stall_mask); else pass_cnt++;
        trd_en = 8'h80;
        tick();
        chk_cnt++; if (cur_vld !== 1'b1 || cur_trd !== 3'd7) $display("FAIL en7: got vld=%b trd=%0d expected vld=1 trd=7", cur_vld, cur_trd); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        trd_en = 8'hFF;
        i_miss = 1'b1; i_miss_trd = 3'd6;
        tick();
        i_miss = 1'b0;
        chk_cnt++; if (stall_mask !== 8'h66) $display("FAIL pre_rst_stall: got %h expected 66", stall_mask); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        chk_cnt++; if (cur_vld !== 1'b0) $display("FAIL arst_vld: got %b expected 0", cur_vld); else pass_cnt++;
        chk_cnt++; if (cur_trd !== 3'd0) $display("FAIL arst_trd: got %0d expected 0", cur_trd); else pass_cnt++;
        chk_cnt++; if (cur_pc !== START_PC) $display("FAIL arst_pc: got %h expected %h", cur_pc, START_PC); else pass_cnt++;
        chk_cnt++; if (stall_mask !== 8'h00) $display("FAIL arst_stall: got %h expected 00", stall_mask); else pass_cnt++;
        trd_en = 8'h00;
        tick();
        rst = 1'b0;
        tick();
        chk_cnt++; if (cur_vld !== 1'b0) $display("FAIL post_rst_idle: got %b expected 0", cur_vld); else pass_cnt++;
        trd_en = 8'hFF;
        tick();
        chk_cnt++; if (cur_vld !== 1'b1 || cur_trd !== 3'd0) $display("FAIL post_rst_first: got vld=%b trd=%0d expected vld=1 trd=0", cur_vld, cur_trd); else pass_cnt++;
        chk_cnt++; if (cur_pc !== START_PC) $display("FAIL post_rst_pc: got %h expected %h", cur_pc, START_PC); else pass_cnt++;
        tick();
        chk_cnt++; if (cur_trd !== 3'd1) $display("FAIL post_rst_second: got %0d expected 1", cur_trd); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_bypass();
        test_miss_skip();
        test_set_wins();
        test_disable();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
